// File: rtl/superh16_pkg.sv
// Shared widths, store-queue entry layout and byte-mask helpers for the
// SuperH16 load/store path.
package superh16_pkg;

   localparam int XLEN         = 64;
   localparam int VADDR_WIDTH  = 64;
   localparam int ROB_IDX_BITS = 7;
   localparam int SQ_DEPTH     = 16;
   localparam int SQ_IDX_BITS  = $clog2(SQ_DEPTH);

   // One extra bit above the index distinguishes full from empty.
   typedef logic [SQ_IDX_BITS:0] sq_ptr_t;

   typedef struct packed {
      logic                    valid;
      logic                    committed;
      logic [VADDR_WIDTH-1:0]  addr;
      logic [XLEN-1:0]         data;
      logic [2:0]              size;
      logic [ROB_IDX_BITS-1:0] rob_idx;
   } sq_entry_t;

   // Bytes touched inside the 8-byte granule; accesses are naturally aligned.
   function automatic logic [7:0] byteMask(input logic [2:0] offset, input logic [2:0] size);
      logic [7:0] base;
      case (size)
         3'd0:    base = 8'h01;
         3'd1:    base = 8'h03;
         3'd2:    base = 8'h0F;
         default: base = 8'hFF;
      endcase
      return base << offset;
   endfunction

   function automatic logic [XLEN-1:0] dataMask(input logic [2:0] size);
      case (size)
         3'd0:    return XLEN'(64'h0000_0000_0000_00FF);
         3'd1:    return XLEN'(64'h0000_0000_0000_FFFF);
         3'd2:    return XLEN'(64'h0000_0000_FFFF_FFFF);
         default: return XLEN'(64'hFFFF_FFFF_FFFF_FFFF);
      endcase
   endfunction

endpackage

// File: rtl/superh16_sq_fwd_search.sv
// Combinational store-to-load forwarding search: finds the youngest valid store
// older than the load's tail snapshot that overlaps the load's bytes.
module superh16_sq_fwd_search
   import superh16_pkg::*;
(
   input  logic                   i_valid [SQ_DEPTH],
   input  logic [VADDR_WIDTH-1:0] i_addr  [SQ_DEPTH],
   input  logic [XLEN-1:0]        i_data  [SQ_DEPTH],
   input  logic [2:0]             i_size  [SQ_DEPTH],
   input  sq_ptr_t                i_head,
   input  sq_ptr_t                i_ldTail,
   input  logic                   i_check,
   input  logic [VADDR_WIDTH-1:0] i_ldAddr,
   input  logic [2:0]             i_ldSize,
   output logic                   o_hit,
   output logic [XLEN-1:0]        o_data,
   output logic                   o_stall
);

   localparam int IW = SQ_IDX_BITS;

   sq_ptr_t       w_candCount;
   logic [7:0]    w_ldMask;
   logic          w_found;
   logic [IW-1:0] w_foundIdx;
   logic [IW-1:0] w_idx;
   logic          w_fullCover;

   // Walk oldest to youngest so the last overlapping entry seen is the youngest.
   always_comb begin
      w_candCount = i_ldTail - i_head;
      w_ldMask    = byteMask(i_ldAddr[2:0], i_ldSize);
      w_found     = 1'b0;
      w_foundIdx  = '0;
      w_idx       = '0;
      for (int k = 0; k < SQ_DEPTH; k++) begin
         w_idx = i_head[IW-1:0] + IW'(k);
         if ((sq_ptr_t'(k) < w_candCount) && i_valid[w_idx] &&
             (i_addr[w_idx][VADDR_WIDTH-1:3] == i_ldAddr[VADDR_WIDTH-1:3]) &&
             ((byteMask(i_addr[w_idx][2:0], i_size[w_idx]) & w_ldMask) != 8'h00)) begin
            w_found    = 1'b1;
            w_foundIdx = w_idx;
         end
      end
      w_fullCover = (i_addr[w_foundIdx] == i_ldAddr) && (i_size[w_foundIdx] >= i_ldSize);
      o_hit   = i_check & w_found & w_fullCover;
      o_stall = i_check & w_found & ~w_fullCover;
      o_data  = o_hit ? (i_data[w_foundIdx] & dataMask(i_ldSize)) : '0;
   end

endmodule

// File: rtl/superh16_store_queue.sv
// Circular store queue: in-order allocate, commit on ROB retire, drain committed
// stores to the D-cache, forward to younger loads, and discard uncommitted on flush.
module superh16_store_queue
   import superh16_pkg::*;
#(
   parameter int SKID = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    sq_alloc,
   input  logic [VADDR_WIDTH-1:0]  sq_addr,
   input  logic [XLEN-1:0]         sq_data,
   input  logic [2:0]              sq_size,
   input  logic [ROB_IDX_BITS-1:0] sq_rob_idx,
   output logic                    sq_full,
   output logic                    sq_empty,
   output logic [SQ_IDX_BITS:0]    sq_tail_snap,
   input  logic                    commit_valid,
   input  logic [ROB_IDX_BITS-1:0] commit_rob_idx,
   output logic                    commit_mismatch,
   input  logic                    flush,
   output logic                    dcache_wr_req,
   output logic [VADDR_WIDTH-1:0]  dcache_wr_addr,
   output logic [XLEN-1:0]         dcache_wr_data,
   output logic [2:0]              dcache_wr_size,
   input  logic                    dcache_wr_ready,
   input  logic                    ld_check,
   input  logic [VADDR_WIDTH-1:0]  ld_addr,
   input  logic [2:0]              ld_size,
   input  logic [SQ_IDX_BITS:0]    ld_sq_tail,
   output logic                    ld_fwd_hit,
   output logic [XLEN-1:0]         ld_fwd_data,
   output logic                    ld_fwd_stall,
   output logic                    sq_overflow
);

   localparam int IW = SQ_IDX_BITS;

   sq_ptr_t   r_head, r_commitPtr, r_tail;
   sq_entry_t r_entries [SQ_DEPTH];
   logic      r_full, r_overflow, r_mismatch;

   sq_ptr_t       w_count, w_countNext, w_headNext, w_commitPtrNext, w_tailNext;
   logic [IW-1:0] w_headIdx, w_commitIdx, w_tailIdx;
   sq_entry_t     w_headEntry;
   sq_entry_t     w_entriesNext [SQ_DEPTH];
   logic          w_countIsFull, w_doAlloc, w_doCommit, w_drain, w_mismatch;

   logic                   w_valid [SQ_DEPTH];
   logic [VADDR_WIDTH-1:0] w_addr  [SQ_DEPTH];
   logic [XLEN-1:0]        w_data  [SQ_DEPTH];
   logic [2:0]             w_size  [SQ_DEPTH];

   assign w_headIdx   = r_head[IW-1:0];
   assign w_commitIdx = r_commitPtr[IW-1:0];
   assign w_tailIdx   = r_tail[IW-1:0];
   assign w_headEntry = r_entries[w_headIdx];
   assign w_count     = r_tail - r_head;

   // Pointer bookkeeping; a flush rewinds the tail to the post-commit pointer.
   always_comb begin
      w_countIsFull   = (w_count == sq_ptr_t'(SQ_DEPTH));
      w_drain         = w_headEntry.valid & w_headEntry.committed & dcache_wr_ready;
      w_doCommit      = commit_valid & (r_commitPtr != r_tail);
      w_mismatch      = commit_valid &
                        ((r_commitPtr == r_tail) | (r_entries[w_commitIdx].rob_idx != commit_rob_idx));
      w_doAlloc       = sq_alloc & ~w_countIsFull & ~flush;
      w_commitPtrNext = r_commitPtr + sq_ptr_t'(w_doCommit);
      w_headNext      = r_head + sq_ptr_t'(w_drain);
      w_tailNext      = flush ? w_commitPtrNext : (r_tail + sq_ptr_t'(w_doAlloc));
      w_countNext     = w_tailNext - w_headNext;
   end

   // Entry updates in priority order: commit, drain, flush discard, then alloc.
   always_comb begin
      w_entriesNext = r_entries;
      if (w_doCommit) begin
         w_entriesNext[w_commitIdx].committed = 1'b1;
      end
      if (w_drain) begin
         w_entriesNext[w_headIdx].valid     = 1'b0;
         w_entriesNext[w_headIdx].committed = 1'b0;
      end
      if (flush) begin
         for (int i = 0; i < SQ_DEPTH; i++) begin
            if (!w_entriesNext[i].committed) begin
               w_entriesNext[i].valid = 1'b0;
            end
         end
      end
      if (w_doAlloc) begin
         w_entriesNext[w_tailIdx] = '{valid: 1'b1, committed: 1'b0, addr: sq_addr,
                                      data: sq_data, size: sq_size, rob_idx: sq_rob_idx};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_head      <= '0;
         r_commitPtr <= '0;
         r_tail      <= '0;
         r_full      <= 1'b0;
         r_overflow  <= 1'b0;
         r_mismatch  <= 1'b0;
         for (int i = 0; i < SQ_DEPTH; i++) begin
            r_entries[i] <= '0;
         end
      end else begin
         r_head      <= w_headNext;
         r_commitPtr <= w_commitPtrNext;
         r_tail      <= w_tailNext;
         r_full      <= (w_countNext >= sq_ptr_t'(SQ_DEPTH - SKID));
         r_overflow  <= sq_alloc & w_countIsFull;
         r_mismatch  <= w_mismatch;
         r_entries   <= w_entriesNext;
      end
   end

   always_comb begin
      for (int i = 0; i < SQ_DEPTH; i++) begin
         w_valid[i] = r_entries[i].valid;
         w_addr[i]  = r_entries[i].addr;
         w_data[i]  = r_entries[i].data;
         w_size[i]  = r_entries[i].size;
      end
   end

   superh16_sq_fwd_search u_fwdSearch (
      .i_valid  (w_valid),
      .i_addr   (w_addr),
      .i_data   (w_data),
      .i_size   (w_size),
      .i_head   (r_head),
      .i_ldTail (ld_sq_tail),
      .i_check  (ld_check),
      .i_ldAddr (ld_addr),
      .i_ldSize (ld_size),
      .o_hit    (ld_fwd_hit),
      .o_data   (ld_fwd_data),
      .o_stall  (ld_fwd_stall)
   );

   assign sq_full         = r_full;
   assign sq_empty        = (r_head == r_tail);
   assign sq_tail_snap    = r_tail;
   assign commit_mismatch = r_mismatch;
   assign sq_overflow     = r_overflow;
   assign dcache_wr_req   = w_headEntry.valid & w_headEntry.committed;
   assign dcache_wr_addr  = w_headEntry.addr;
   assign dcache_wr_data  = w_headEntry.data;
   assign dcache_wr_size  = w_headEntry.size;

endmodule

// File: tb/tb_superh16_store_queue.sv
// Self-checking bench for superh16_store_queue: directed vectors, corner-case
// sequences and a randomized run against a queue-based reference model.
module tb_superh16_store_queue;
   import superh16_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic sqAlloc = 1'b0, commitValid = 1'b0, flushIn = 1'b0, wrReady = 1'b0, ldCheck = 1'b0;
   logic [VADDR_WIDTH-1:0] sqAddr = '0, ldAddr = '0;
   logic [XLEN-1:0] sqData = '0;
   logic [2:0] sqSize = '0, ldSize = '0;
   logic [ROB_IDX_BITS-1:0] sqRob = '0, commitRob = '0;
   logic [SQ_IDX_BITS:0] ldTail = '0;
   logic sqFull, sqEmpty, commitMismatch, wrReq, fwdHit, fwdStall, sqOverflow;
   logic [SQ_IDX_BITS:0] tailSnap;
   logic [VADDR_WIDTH-1:0] wrAddr;
   logic [XLEN-1:0] wrData, fwdData;
   logic [2:0] wrSize;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   superh16_store_queue dut (
      .clk(clk), .rst(rst), .sq_alloc(sqAlloc), .sq_addr(sqAddr), .sq_data(sqData),
      .sq_size(sqSize), .sq_rob_idx(sqRob), .sq_full(sqFull), .sq_empty(sqEmpty),
      .sq_tail_snap(tailSnap), .commit_valid(commitValid), .commit_rob_idx(commitRob),
      .commit_mismatch(commitMismatch), .flush(flushIn), .dcache_wr_req(wrReq),
      .dcache_wr_addr(wrAddr), .dcache_wr_data(wrData), .dcache_wr_size(wrSize),
      .dcache_wr_ready(wrReady), .ld_check(ldCheck), .ld_addr(ldAddr), .ld_size(ldSize),
      .ld_sq_tail(ldTail), .ld_fwd_hit(fwdHit), .ld_fwd_data(fwdData),
      .ld_fwd_stall(fwdStall), .sq_overflow(sqOverflow)
   );

   typedef struct {
      logic alloc; logic [63:0] addr; logic [63:0] data; logic [2:0] size; logic [6:0] rob;
      logic commit; logic [6:0] commitRob; logic flush; logic ready;
      logic ldCheck; logic [63:0] ldAddr; logic [2:0] ldSize; int ldSnap;
   } stim_t;

   typedef struct {
      stim_t s; logic expReq; logic [63:0] expData; logic expEmpty; logic [4:0] expSnap; logic expMm;
   } vec_t;

   typedef struct { logic [63:0] addr; logic [63:0] data; logic [2:0] size; logic [6:0] rob; } mEnt_t;

   // Reference model: queue ordered oldest-first; the first mCommitted are committed.
   mEnt_t mq[$];
   int mCommitted = 0, mHeadAbs = 0, mTailAbs = 0;
   logic expOverflow = 1'b0, expMismatch = 1'b0;

   logic gotReq, gotHit, gotStall;
   logic [63:0] gotAddr, gotData, gotFwd;
   logic [2:0] gotSize;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   function automatic stim_t idleStim();
      stim_t s;
      s = '{alloc: 0, addr: 0, data: 0, size: 0, rob: 0, commit: 0, commitRob: 0, flush: 0,
            ready: 1, ldCheck: 0, ldAddr: 0, ldSize: 0, ldSnap: 0};
      return s;
   endfunction

   function automatic stim_t allocStim(input logic [63:0] a, input logic [63:0] d,
                                       input logic [2:0] sz, input logic [6:0] r);
      stim_t s;
      s = idleStim();
      s.alloc = 1; s.addr = a; s.data = d; s.size = sz; s.rob = r;
      return s;
   endfunction

   function automatic stim_t commitStim(input logic [6:0] r);
      stim_t s;
      s = idleStim();
      s.commit = 1; s.commitRob = r;
      return s;
   endfunction

   function automatic logic [63:0] sizeMask(input logic [2:0] sz);
      case (sz)
         3'd0: return 64'hFF;
         3'd1: return 64'hFFFF;
         3'd2: return 64'hFFFF_FFFF;
         default: return 64'hFFFF_FFFF_FFFF_FFFF;
      endcase
   endfunction

   // Youngest older store whose byte interval intersects the load's interval wins.
   task automatic modelFwd(input stim_t s, output logic hit, output logic stall, output logic [63:0] data);
      logic [63:0] sa, se, la, le;
      hit = 0; stall = 0; data = 0;
      la = s.ldAddr;
      le = la + (64'd1 << s.ldSize);
      for (int k = 0; k < mq.size(); k++) begin
         if (mHeadAbs + k < s.ldSnap) begin
            sa = mq[k].addr;
            se = sa + (64'd1 << mq[k].size);
            if ((sa >> 3) == (la >> 3) && sa < le && la < se) begin
               if (sa == la && mq[k].size >= s.ldSize) begin
                  hit = 1; stall = 0; data = mq[k].data & sizeMask(s.ldSize);
               end else begin
                  hit = 0; stall = 1; data = 0;
               end
            end
         end
      end
   endtask

   task automatic applyStimulus(input stim_t s);
      int snap;
      snap = s.ldSnap;
      sqAlloc = s.alloc; sqAddr = s.addr; sqData = s.data; sqSize = s.size; sqRob = s.rob;
      commitValid = s.commit; commitRob = s.commitRob; flushIn = s.flush; wrReady = s.ready;
      ldCheck = s.ldCheck; ldAddr = s.ldAddr; ldSize = s.ldSize; ldTail = snap[4:0];
   endtask

   task automatic modelStep(input stim_t s);
      int n0, c0;
      logic accept;
      n0 = mq.size();
      c0 = mCommitted;
      accept = s.alloc && !s.flush && n0 < SQ_DEPTH;
      expOverflow = s.alloc && n0 == SQ_DEPTH;
      expMismatch = s.commit && (c0 == n0 || mq[c0].rob != s.commitRob);
      if (s.commit && c0 < n0) mCommitted++;
      if (c0 > 0 && s.ready) begin
         void'(mq.pop_front());
         mCommitted--;
         mHeadAbs++;
      end
      if (s.flush) begin
         while (mq.size() > mCommitted) void'(mq.pop_back());
         mTailAbs = mHeadAbs + mq.size();
      end else if (accept) begin
         mq.push_back('{addr: s.addr, data: s.data, size: s.size, rob: s.rob});
         mTailAbs++;
      end
   endtask

   // Called just after a rising edge: drive, check combinational outputs at the
   // falling edge, then check registered outputs after the next rising edge.
   task automatic runCycle(input stim_t s);
      logic eHit, eStall;
      logic [63:0] eFwd;
      logic [4:0] eSnap;
      applyStimulus(s);
      @(negedge clk);
      gotReq = wrReq; gotAddr = wrAddr; gotData = wrData; gotSize = wrSize;
      gotHit = fwdHit; gotStall = fwdStall; gotFwd = fwdData;
      checkOutput("model.wrReq", gotReq, mCommitted > 0);
      if (mCommitted > 0) begin
         checkOutput("model.wrAddr", gotAddr, mq[0].addr);
         checkOutput("model.wrData", gotData, mq[0].data);
         checkOutput("model.wrSize", gotSize, mq[0].size);
      end
      modelFwd(s, eHit, eStall, eFwd);
      checkOutput("model.fwdHit", gotHit, s.ldCheck & eHit);
      checkOutput("model.fwdStall", gotStall, s.ldCheck & eStall);
      checkOutput("model.fwdData", gotFwd, s.ldCheck ? eFwd : 64'h0);
      @(posedge clk);
      #1;
      modelStep(s);
      eSnap = mTailAbs[4:0];
      checkOutput("model.full", sqFull, mq.size() >= SQ_DEPTH - 2);
      checkOutput("model.empty", sqEmpty, mq.size() == 0);
      checkOutput("model.tailSnap", tailSnap, eSnap);
      checkOutput("model.overflow", sqOverflow, expOverflow);
      checkOutput("model.mismatch", commitMismatch, expMismatch);
   endtask

   task automatic doReset();
      applyStimulus(idleStim());
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      mq.delete();
      mCommitted = 0; mHeadAbs = 0; mTailAbs = 0;
      checkOutput("reset.empty", sqEmpty, 1'b1);
      checkOutput("reset.full", sqFull, 1'b0);
      checkOutput("reset.tailSnap", tailSnap, 5'd0);
      checkOutput("reset.wrReq", wrReq, 1'b0);
      checkOutput("reset.wrAddr", wrAddr, 64'h0);
      checkOutput("reset.overflow", sqOverflow, 1'b0);
      checkOutput("reset.mismatch", commitMismatch, 1'b0);
      rst = 1'b0;
   endtask

   vec_t vecs[10];

   initial begin
      stim_t st;
      int drains;
      logic done;
      logic [6:0] robCtr;

      // Directed table: three stores, in-order commits and drains, mismatches.
      st = allocStim(64'h100, 64'h55, 3, 7'd5);           vecs[0] = '{st, 0, 64'h0, 0, 5'd1, 0};
      st = allocStim(64'h108, 64'h66, 3, 7'd6);           vecs[1] = '{st, 0, 64'h0, 0, 5'd2, 0};
      st = allocStim(64'h110, 64'h77, 3, 7'd7);
      st.commit = 1; st.commitRob = 7'd5;                 vecs[2] = '{st, 0, 64'h0, 0, 5'd3, 0};
      st = commitStim(7'd6);                              vecs[3] = '{st, 1, 64'h55, 0, 5'd3, 0};
      st = idleStim();                                    vecs[4] = '{st, 1, 64'h66, 0, 5'd3, 0};
      st = idleStim();                                    vecs[5] = '{st, 0, 64'h0, 0, 5'd3, 0};
      st = commitStim(7'd9);                              vecs[6] = '{st, 0, 64'h0, 0, 5'd3, 1};
      st = idleStim();                                    vecs[7] = '{st, 1, 64'h77, 1, 5'd3, 0};
      st = commitStim(7'd7);                              vecs[8] = '{st, 0, 64'h0, 1, 5'd3, 1};
      st = idleStim();                                    vecs[9] = '{st, 0, 64'h0, 1, 5'd3, 0};

      doReset();
      for (int i = 0; i < 10; i++) begin
         runCycle(vecs[i].s);
         checkOutput($sformatf("vec%0d.req", i), gotReq, vecs[i].expReq);
         if (vecs[i].expReq) checkOutput($sformatf("vec%0d.data", i), gotData, vecs[i].expData);
         checkOutput($sformatf("vec%0d.empty", i), sqEmpty, vecs[i].expEmpty);
         checkOutput($sformatf("vec%0d.snap", i), tailSnap, vecs[i].expSnap);
         checkOutput($sformatf("vec%0d.mismatch", i), commitMismatch, vecs[i].expMm);
      end

      // Fill to the skid threshold, then to capacity, then overflow.
      doReset();
      for (int i = 0; i < 17; i++) begin
         runCycle(allocStim(64'h400 + 64'(i * 8), 64'(i), 3, 7'(i)));
         if (i == 12) checkOutput("fill.fullAt13", sqFull, 1'b0);
         if (i == 13) checkOutput("fill.fullAt14", sqFull, 1'b1);
         if (i == 15) checkOutput("fill.overflowAt16", sqOverflow, 1'b0);
      end
      checkOutput("fill.overflowAt17", sqOverflow, 1'b1);
      checkOutput("fill.tailAt17", tailSnap, 5'd16);
      runCycle(idleStim());
      checkOutput("fill.overflowCleared", sqOverflow, 1'b0);

      // Flush together with a third commit and an alloc keeps exactly three stores.
      doReset();
      for (int i = 0; i < 5; i++) runCycle(allocStim(64'h800 + 64'(i * 8), 64'hA0 + 64'(i), 3, 7'(20 + i)));
      st = commitStim(7'd20); st.ready = 0; runCycle(st);
      st = commitStim(7'd21); st.ready = 0; runCycle(st);
      st = allocStim(64'h900, 64'hBAD, 3, 7'd30);
      st.commit = 1; st.commitRob = 7'd22; st.flush = 1; st.ready = 0; runCycle(st);
      checkOutput("flush.tailSnap", tailSnap, 5'd3);
      drains = 0; done = 0;
      for (int n = 0; n < 20 && !done; n++) begin
         runCycle(idleStim());
         if (gotReq) drains++;
         if (sqEmpty) done = 1;
      end
      checkOutput("flush.drains", drains, 3);
      checkOutput("flush.emptied", done, 1'b1);

      // Forwarding: sub-word hit and partial-overlap stall.
      doReset();
      runCycle(allocStim(64'h1000, 64'h1122334455667788, 3, 7'd40));
      st = idleStim(); st.ldCheck = 1; st.ldAddr = 64'h1000; st.ldSize = 2; st.ldSnap = 1;
      runCycle(st);
      checkOutput("fwd.hit", gotHit, 1'b1);
      checkOutput("fwd.data", gotFwd, 64'h55667788);
      st.ldAddr = 64'h1004; runCycle(st);
      checkOutput("fwd.stall", gotStall, 1'b1);
      checkOutput("fwd.stallNoHit", gotHit, 1'b0);

      // Age ordering: snapshot decides which of two same-address stores is visible.
      doReset();
      runCycle(allocStim(64'h2000, 64'hAAAA_0000_AAAA_0001, 3, 7'd50));
      runCycle(allocStim(64'h2000, 64'hBBBB_0000_BBBB_0002, 3, 7'd51));
      st = idleStim(); st.ldCheck = 1; st.ldAddr = 64'h2000; st.ldSize = 3;
      st.ldSnap = 2; runCycle(st);
      checkOutput("age.youngest", gotFwd, 64'hBBBB_0000_BBBB_0002);
      st.ldSnap = 1; runCycle(st);
      checkOutput("age.older", gotFwd, 64'hAAAA_0000_AAAA_0001);
      st.ldSnap = 0; runCycle(st);
      checkOutput("age.noneHit", gotHit, 1'b0);
      checkOutput("age.noneStall", gotStall, 1'b0);

      // Back-pressure: committed head holds its request steady while not ready.
      doReset();
      runCycle(allocStim(64'h3008, 64'hCAFE_F00D_1234_5678, 3, 7'd60));
      st = commitStim(7'd60); st.ready = 0; runCycle(st);
      for (int i = 0; i < 5; i++) begin
         st = idleStim(); st.ready = 0; runCycle(st);
         checkOutput($sformatf("hold%0d.req", i), gotReq, 1'b1);
         checkOutput($sformatf("hold%0d.addr", i), gotAddr, 64'h3008);
         checkOutput($sformatf("hold%0d.data", i), gotData, 64'hCAFE_F00D_1234_5678);
      end
      runCycle(idleStim());
      checkOutput("hold.drained", sqEmpty, 1'b1);

      // Randomized mixed traffic; pointers wrap many times.
      robCtr = 7'd0;
      for (int n = 0; n < 400; n++) begin
         st = idleStim();
         st.ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 2) != 0) begin
            st.alloc = 1;
            st.size = 3'($urandom_range(0, 3));
            st.addr = 64'h3000 + 64'($urandom_range(0, 1) * 8) + 64'(($urandom_range(0, 7) >> st.size) << st.size);
            st.data = {$urandom, $urandom};
            st.rob = robCtr;
            robCtr++;
         end
         if ($urandom_range(0, 2) == 0) begin
            st.commit = 1;
            st.commitRob = (mCommitted < mq.size()) ? mq[mCommitted].rob : 7'($urandom);
            if ($urandom_range(0, 9) == 0) st.commitRob = st.commitRob + 7'd1;
         end
         st.flush = ($urandom_range(0, 29) == 0);
         st.ldCheck = $urandom_range(0, 1);
         st.ldSize = 3'($urandom_range(0, 3));
         st.ldAddr = 64'h3000 + 64'($urandom_range(0, 1) * 8) + 64'(($urandom_range(0, 7) >> st.ldSize) << st.ldSize);
         st.ldSnap = $urandom_range(mHeadAbs, mTailAbs);
         runCycle(st);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
